// File: rtl/invader_grid_renderer_pkg.sv
// Shared geometry, march step sizes and march-state encoding for the
// invader grid renderer.
package invader_grid_renderer_pkg;

  // Cell pitch and the sprite area inside the cell's top-left corner
  localparam logic [9:0] CELL_W     = 10'd40;
  localparam logic [9:0] CELL_H     = 10'd24;
  localparam logic [9:0] SPR_W      = 10'd32;
  localparam logic [9:0] SPR_H      = 10'd16;

  // March step sizes
  localparam logic [9:0] STEP_X     = 10'd4;
  localparam logic [9:0] STEP_Y     = 10'd8;

  // Grid origin after reset
  localparam logic [9:0] START_X    = 10'd40;
  localparam logic [9:0] START_Y    = 10'd48;

  // Screen limits
  localparam logic [9:0] INVASION_Y = 10'd440;
  localparam logic [9:0] SCREEN_W   = 10'd640;
  localparam logic [9:0] FRAME_LINE = 10'd480;

  typedef enum logic {
    MARCH_RIGHT = 1'b0,
    MARCH_LEFT  = 1'b1
  } march_state_e;

endpackage

// File: rtl/invader_grid_renderer_sprite_rom.sv
// Two-frame 16x8 invader bitmap. Bit 0 of each line is the leftmost pixel.
module invader_sprite_rom (
  input  logic        anim_sel,
  input  logic [2:0]  line,
  output logic [15:0] bits
);

  // Combinational lookup; the two frames differ only in the legs (lines 5..7)
  always_comb begin
    bits = 16'h0000;
    case ({anim_sel, line})
      4'b0_000: bits = 16'h0FF0;
      4'b0_001: bits = 16'h3FFC;
      4'b0_010: bits = 16'hF3CF;
      4'b0_011: bits = 16'hFFFF;
      4'b0_100: bits = 16'h3C3C;
      4'b0_101: bits = 16'h6666;
      4'b0_110: bits = 16'hC003;
      4'b0_111: bits = 16'h6006;
      4'b1_000: bits = 16'h0FF0;
      4'b1_001: bits = 16'h3FFC;
      4'b1_010: bits = 16'hF3CF;
      4'b1_011: bits = 16'hFFFF;
      4'b1_100: bits = 16'h3C3C;
      4'b1_101: bits = 16'h9999;
      4'b1_110: bits = 16'h300C;
      4'b1_111: bits = 16'h0C30;
      default:  bits = 16'h0000;
    endcase
  end

endmodule

// File: rtl/invader_grid_renderer.sv
// Invader grid: per-pixel sprite rendering, frame-locked marching and
// alien removal. All state changes on the pixel clock.
module invader_grid_renderer
  import invader_grid_renderer_pkg::*;
#(
  parameter int COLS         = 8,
  parameter int ROWS         = 4,
  parameter int MARCH_FRAMES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       display_on,
  input  logic       kill_valid,
  input  logic [1:0] kill_row,
  input  logic [2:0] kill_col,
  output logic       alien_pixel,
  output logic [9:0] grid_x,
  output logic [9:0] grid_y,
  output logic [5:0] alive_count,
  output logic       all_dead,
  output logic       reached_bottom
);

  localparam int         NCELLS     = ROWS * COLS;
  localparam logic [9:0] GRID_W     = 10'(COLS * int'(CELL_W));
  localparam logic [9:0] GRID_H     = 10'(ROWS * int'(CELL_H));
  localparam logic [5:0] CELLS_L    = 6'(NCELLS);
  localparam logic [7:0] LAST_FRAME = 8'(MARCH_FRAMES - 1);
  localparam logic [2:0] ROWS_L     = 3'(ROWS);
  localparam logic [3:0] COLS_L     = 4'(COLS);

  march_state_e      state_q, state_d;
  logic [NCELLS-1:0] alive_q, alive_d;
  logic [5:0]        alive_count_q, alive_count_d;
  logic [9:0]        grid_x_q, grid_x_d;
  logic [9:0]        grid_y_q, grid_y_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic              anim_sel_q, anim_sel_d;
  logic              alien_pixel_q, alien_pixel_d;
  logic              reached_bottom_q, reached_bottom_d;

  logic              frame_tick, march_step, at_edge;
  logic              do_right, do_left, do_drop;
  logic              kill_hit;
  logic [9:0]        rel_x, rel_y, x_rem, y_rem;
  int                col_i, row_i;
  logic              in_grid, in_sprite, cell_alive;
  logic [15:0]       rom_bits;

  assign all_dead   = (alive_count_q == 6'd0);
  assign frame_tick = (hpos == 10'd0) && (vpos == FRAME_LINE);
  assign march_step = frame_tick && (frame_cnt_q == LAST_FRAME)
                      && !reached_bottom_q && !all_dead;

  // A step at the screen edge becomes a drop instead of a horizontal move
  assign at_edge = (state_q == MARCH_RIGHT)
                   ? ((grid_x_q + GRID_W + STEP_X) > SCREEN_W)
                   : (grid_x_q < STEP_X);

  // March state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= MARCH_RIGHT;
    else       state_q <= state_d;
  end

  // Next march direction: reverse on every drop
  always_comb begin
    state_d = state_q;
    if (march_step && at_edge)
      state_d = (state_q == MARCH_RIGHT) ? MARCH_LEFT : MARCH_RIGHT;
  end

  // Decode the kind of step taken this cycle
  always_comb begin
    do_right = 1'b0;
    do_left  = 1'b0;
    do_drop  = 1'b0;
    if (march_step) begin
      if (at_edge)                     do_drop  = 1'b1;
      else if (state_q == MARCH_RIGHT) do_right = 1'b1;
      else                             do_left  = 1'b1;
    end
  end

  // Frame counter, grid origin, animation frame and invasion flag
  always_comb begin
    frame_cnt_d      = frame_cnt_q;
    grid_x_d         = grid_x_q;
    grid_y_d         = grid_y_q;
    anim_sel_d       = anim_sel_q;
    reached_bottom_d = reached_bottom_q;
    if (frame_tick)
      frame_cnt_d = (frame_cnt_q == LAST_FRAME) ? 8'd0 : frame_cnt_q + 8'd1;
    if (do_right) grid_x_d = grid_x_q + STEP_X;
    if (do_left)  grid_x_d = grid_x_q - STEP_X;
    if (do_drop)  grid_y_d = grid_y_q + STEP_Y;
    if (march_step) begin
      anim_sel_d = ~anim_sel_q;
      if ((grid_y_d + GRID_H) >= INVASION_Y) reached_bottom_d = 1'b1;
    end
  end

  // Kill request: clears a live in-range cell and decrements the count
  always_comb begin
    alive_d  = alive_q;
    kill_hit = 1'b0;
    if (kill_valid && ({1'b0, kill_row} < ROWS_L) && ({1'b0, kill_col} < COLS_L)) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          if ((int'(kill_row) == r) && (int'(kill_col) == c) && alive_q[r*COLS + c]) begin
            alive_d[r*COLS + c] = 1'b0;
            kill_hit            = 1'b1;
          end
        end
      end
    end
    alive_count_d = kill_hit ? (alive_count_q - 6'd1) : alive_count_q;
  end

  // Pixel geometry: cell index by repeated compare-and-subtract of the cell pitch
  always_comb begin
    rel_x   = hpos - grid_x_q;
    rel_y   = vpos - grid_y_q;
    in_grid = (hpos >= grid_x_q) && (rel_x < GRID_W)
              && (vpos >= grid_y_q) && (rel_y < GRID_H);
    x_rem = rel_x;
    col_i = 0;
    for (int c = 1; c < COLS; c++) begin
      if (x_rem >= CELL_W) begin
        x_rem = x_rem - CELL_W;
        col_i = col_i + 1;
      end
    end
    y_rem = rel_y;
    row_i = 0;
    for (int r = 1; r < ROWS; r++) begin
      if (y_rem >= CELL_H) begin
        y_rem = y_rem - CELL_H;
        row_i = row_i + 1;
      end
    end
    in_sprite  = (x_rem < SPR_W) && (y_rem < SPR_H);
    cell_alive = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if ((row_i == r) && (col_i == c)) cell_alive = alive_q[r*COLS + c];
      end
    end
  end

  invader_sprite_rom u_rom (
    .anim_sel (anim_sel_q),
    .line     (y_rem[3:1]),
    .bits     (rom_bits)
  );

  // Pixel decision; the 2x scaling drops bit 0 of the in-cell offset
  always_comb begin
    alien_pixel_d = display_on && in_grid && in_sprite && cell_alive
                    && rom_bits[x_rem[4:1]];
  end

  // Datapath registers; reset wins over every concurrent update
  always_ff @(posedge clk) begin
    if (reset) begin
      alive_q          <= '1;
      alive_count_q    <= CELLS_L;
      grid_x_q         <= START_X;
      grid_y_q         <= START_Y;
      frame_cnt_q      <= 8'd0;
      anim_sel_q       <= 1'b0;
      alien_pixel_q    <= 1'b0;
      reached_bottom_q <= 1'b0;
    end else begin
      alive_q          <= alive_d;
      alive_count_q    <= alive_count_d;
      grid_x_q         <= grid_x_d;
      grid_y_q         <= grid_y_d;
      frame_cnt_q      <= frame_cnt_d;
      anim_sel_q       <= anim_sel_d;
      alien_pixel_q    <= alien_pixel_d;
      reached_bottom_q <= reached_bottom_d;
    end
  end

  assign alien_pixel    = alien_pixel_q;
  assign grid_x         = grid_x_q;
  assign grid_y         = grid_y_q;
  assign alive_count    = alive_count_q;
  assign reached_bottom = reached_bottom_q;

endmodule

// File: tb/tb_invader_grid_renderer.sv
// Directed bench for invader_grid_renderer: reset, rendering, marching,
// kills, extinction and invasion.
module tb_invader_grid_renderer;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] hpos, vpos;
  logic       display_on, kill_valid;
  logic [1:0] kill_row;
  logic [2:0] kill_col;
  logic       alien_pixel, all_dead, reached_bottom;
  logic [9:0] grid_x, grid_y;
  logic [5:0] alive_count;

  int vectors = 0;
  int miscompares = 0;

  // Reference state
  int m_x, m_y, m_cnt, m_count;
  bit m_left, m_anim, m_rb;
  bit m_alive [4][8];

  invader_grid_renderer #(.COLS(8), .ROWS(4), .MARCH_FRAMES(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .hpos           (hpos),
    .vpos           (vpos),
    .display_on     (display_on),
    .kill_valid     (kill_valid),
    .kill_row       (kill_row),
    .kill_col       (kill_col),
    .alien_pixel    (alien_pixel),
    .grid_x         (grid_x),
    .grid_y         (grid_y),
    .alive_count    (alive_count),
    .all_dead       (all_dead),
    .reached_bottom (reached_bottom)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] tb_rom(bit a, int line);
    logic [15:0] b;
    case (line)
      0: b = 16'h0FF0;
      1: b = 16'h3FFC;
      2: b = 16'hF3CF;
      3: b = 16'hFFFF;
      4: b = 16'h3C3C;
      5: b = a ? 16'h9999 : 16'h6666;
      6: b = a ? 16'h300C : 16'hC003;
      default: b = a ? 16'h0C30 : 16'h6006;
    endcase
    return b;
  endfunction

  function automatic logic exp_pixel(int h, int v, logic disp);
    int rx, ry, col, row, cx, cy;
    logic [15:0] b;
    if (!disp) return 1'b0;
    rx = h - m_x;
    ry = v - m_y;
    if (rx < 0 || ry < 0 || rx >= 320 || ry >= 96) return 1'b0;
    col = rx / 40; cx = rx % 40;
    row = ry / 24; cy = ry % 24;
    if (cx >= 32 || cy >= 16) return 1'b0;
    if (!m_alive[row][col]) return 1'b0;
    b = tb_rom(m_anim, cy / 2);
    return b[cx / 2];
  endfunction

  function automatic void model_reset();
    m_x = 40; m_y = 48; m_cnt = 0; m_count = 32;
    m_left = 0; m_anim = 0; m_rb = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++) m_alive[r][c] = 1'b1;
  endfunction

  function automatic void model_tick();
    if (m_cnt == 7) begin
      m_cnt = 0;
      if (!m_rb && m_count != 0) begin
        if (!m_left) begin
          if (m_x + 320 + 4 > 640) begin m_y += 8; m_left = 1; end
          else m_x += 4;
        end else begin
          if (m_x < 4) begin m_y += 8; m_left = 0; end
          else m_x -= 4;
        end
        m_anim = !m_anim;
        if (m_y + 96 >= 440) m_rb = 1;
      end
    end else begin
      m_cnt++;
    end
  endfunction

  task automatic idle_inputs();
    hpos = 10'd1; vpos = 10'd0; display_on = 1'b0;
    kill_valid = 1'b0; kill_row = 2'd0; kill_col = 3'd0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  // One frame_tick cycle followed by one ordinary cycle
  task automatic do_tick();
    hpos = 10'd0; vpos = 10'd480; display_on = 1'b0;
    @(posedge clk); #1;
    model_tick();
    hpos = 10'd1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    hpos = 10'd48; vpos = 10'd48; display_on = 1'b1;
    kill_valid = 1'b1; kill_row = 2'd0; kill_col = 3'd1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    vectors += 6;
    if (grid_x !== 10'd40) begin miscompares++; $display("FAIL reset_grid_x got=%0d exp=40", grid_x); end
    if (grid_y !== 10'd48) begin miscompares++; $display("FAIL reset_grid_y got=%0d exp=48", grid_y); end
    if (alive_count !== 6'd32) begin miscompares++; $display("FAIL reset_alive_count got=%0d exp=32", alive_count); end
    if (all_dead !== 1'b0) begin miscompares++; $display("FAIL reset_all_dead got=%b exp=0", all_dead); end
    if (reached_bottom !== 1'b0) begin miscompares++; $display("FAIL reset_reached_bottom got=%b exp=0", reached_bottom); end
    if (alien_pixel !== 1'b0) begin miscompares++; $display("FAIL reset_alien_pixel got=%b exp=0", alien_pixel); end
    reset = 1'b0;
    model_reset();
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_pixels();
    int lines [8] = '{48, 49, 58, 63, 64, 125, 143, 144};
    logic e;
    apply_reset();
    for (int li = 0; li < 8; li++) begin
      for (int h = 30; h <= 365; h++) begin
        hpos = 10'(h); vpos = 10'(lines[li]); display_on = 1'b1;
        e = exp_pixel(h, lines[li], 1'b1);
        @(posedge clk); #1;
        hpos = 10'd0; vpos = 10'd0; display_on = 1'b0;
        #1;
        vectors++;
        if (alien_pixel !== e) begin
          miscompares++;
          $display("FAIL pixel h=%0d v=%0d got=%b exp=%b", h, lines[li], alien_pixel, e);
        end
      end
    end
    // Blanked video never lights a pixel
    for (int h = 40; h <= 60; h++) begin
      hpos = 10'(h); vpos = 10'd48; display_on = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if (alien_pixel !== 1'b0) begin
        miscompares++;
        $display("FAIL pixel_blank h=%0d got=%b exp=0", h, alien_pixel);
      end
    end
    vectors += 3;
    if (grid_x !== 10'd40) begin miscompares++; $display("FAIL frame_grid_x got=%0d exp=40", grid_x); end
    if (grid_y !== 10'd48) begin miscompares++; $display("FAIL frame_grid_y got=%0d exp=48", grid_y); end
    if (alive_count !== 6'd32) begin miscompares++; $display("FAIL frame_alive_count got=%0d exp=32", alive_count); end
  endtask

  task automatic test_march_step();
    apply_reset();
    for (int i = 0; i < 7; i++) do_tick();
    // Near misses of the tick condition must not move the grid
    hpos = 10'd1; vpos = 10'd480; @(posedge clk); #1;
    hpos = 10'd0; vpos = 10'd479; @(posedge clk); #1;
    hpos = 10'd0; vpos = 10'd481; @(posedge clk); #1;
    vectors++;
    if (grid_x !== 10'd40) begin miscompares++; $display("FAIL march_before_x got=%0d exp=40", grid_x); end
    // Leg pixel in anim frame 0 is dark at bit 0
    hpos = 10'd40; vpos = 10'd58; display_on = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (alien_pixel !== 1'b0) begin miscompares++; $display("FAIL anim0_leg got=%b exp=0", alien_pixel); end
    hpos = 10'd0; vpos = 10'd480; display_on = 1'b0;
    @(posedge clk); #1;
    model_tick();
    vectors += 2;
    if (grid_x !== 10'd44) begin miscompares++; $display("FAIL march_step_x got=%0d exp=44", grid_x); end
    if (grid_y !== 10'd48) begin miscompares++; $display("FAIL march_step_y got=%0d exp=48", grid_y); end
    // anim_sel=1: bit 0 of leg line lit, bit 1 dark
    hpos = 10'd44; vpos = 10'd58; display_on = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (alien_pixel !== 1'b1) begin miscompares++; $display("FAIL anim1_leg0 got=%b exp=1", alien_pixel); end
    hpos = 10'd46;
    @(posedge clk); #1;
    vectors++;
    if (alien_pixel !== 1'b0) begin miscompares++; $display("FAIL anim1_leg1 got=%b exp=0", alien_pixel); end
    idle_inputs();
  endtask

  task automatic test_kill();
    logic e;
    apply_reset();
    kill_valid = 1'b1; kill_row = 2'd2; kill_col = 3'd5;
    @(posedge clk); #1;
    kill_valid = 1'b0;
    m_alive[2][5] = 1'b0; m_count--;
    vectors++;
    if (alive_count !== 6'd31) begin miscompares++; $display("FAIL kill_count got=%0d exp=31", alive_count); end
    for (int pass = 0; pass < 2; pass++) begin
      for (int h = 236; h <= 290; h++) begin
        hpos = 10'(h); vpos = 10'd98; display_on = 1'b1;
        e = exp_pixel(h, 98, 1'b1);
        @(posedge clk); #1;
        vectors++;
        if (alien_pixel !== e) begin
          miscompares++;
          $display("FAIL kill_dark pass=%0d h=%0d got=%b exp=%b", pass, h, alien_pixel, e);
        end
      end
      if (pass == 0) begin
        kill_valid = 1'b1; kill_row = 2'd2; kill_col = 3'd5;
        @(posedge clk); #1;
        kill_valid = 1'b0;
        vectors++;
        if (alive_count !== 6'd31) begin miscompares++; $display("FAIL kill_repeat got=%0d exp=31", alive_count); end
        for (int i = 0; i < 8; i++) do_tick();
        vectors++;
        if (grid_x !== 10'd44) begin miscompares++; $display("FAIL kill_frame_x got=%0d exp=44", grid_x); end
      end
    end
    // Kill landing on the same edge as a march step
    for (int i = 0; i < 7; i++) do_tick();
    hpos = 10'd0; vpos = 10'd480; display_on = 1'b0;
    kill_valid = 1'b1; kill_row = 2'd0; kill_col = 3'd0;
    @(posedge clk); #1;
    kill_valid = 1'b0;
    model_tick();
    m_alive[0][0] = 1'b0; m_count--;
    vectors += 2;
    if (grid_x !== 10'd48) begin miscompares++; $display("FAIL kill_step_x got=%0d exp=48", grid_x); end
    if (alive_count !== 6'd30) begin miscompares++; $display("FAIL kill_step_count got=%0d exp=30", alive_count); end
    // Kill during rendering of that very cell: this pixel still lit, next dark
    hpos = 10'd96; vpos = 10'd48; display_on = 1'b1;
    kill_valid = 1'b1; kill_row = 2'd0; kill_col = 3'd1;
    @(posedge clk); #1;
    kill_valid = 1'b0;
    vectors++;
    if (alien_pixel !== 1'b1) begin miscompares++; $display("FAIL kill_same_pixel got=%b exp=1", alien_pixel); end
    @(posedge clk); #1;
    m_alive[0][1] = 1'b0; m_count--;
    vectors += 2;
    if (alien_pixel !== 1'b0) begin miscompares++; $display("FAIL kill_next_pixel got=%b exp=0", alien_pixel); end
    if (alive_count !== 6'd29) begin miscompares++; $display("FAIL kill_pixel_count got=%0d exp=29", alive_count); end
    idle_inputs();
  endtask

  task automatic test_all_dead();
    int n;
    apply_reset();
    n = 32;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 8; c++) begin
        kill_valid = 1'b1; kill_row = 2'(r); kill_col = 3'(c);
        @(posedge clk); #1;
        n--;
        m_alive[r][c] = 1'b0; m_count--;
        vectors += 2;
        if (alive_count !== 6'(n)) begin miscompares++; $display("FAIL dead_count got=%0d exp=%0d", alive_count, n); end
        if (all_dead !== (n == 0)) begin miscompares++; $display("FAIL dead_flag n=%0d got=%b", n, all_dead); end
      end
    end
    kill_valid = 1'b0;
    for (int i = 0; i < 16; i++) do_tick();
    vectors += 4;
    if (grid_x !== 10'd40) begin miscompares++; $display("FAIL dead_frozen_x got=%0d exp=40", grid_x); end
    if (grid_y !== 10'd48) begin miscompares++; $display("FAIL dead_frozen_y got=%0d exp=48", grid_y); end
    if (all_dead !== 1'b1) begin miscompares++; $display("FAIL dead_final got=%b exp=1", all_dead); end
    if (alive_count !== 6'd0) begin miscompares++; $display("FAIL dead_final_count got=%0d exp=0", alive_count); end
    hpos = 10'd48; vpos = 10'd48; display_on = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (alien_pixel !== 1'b0) begin miscompares++; $display("FAIL dead_pixel got=%b exp=0", alien_pixel); end
    idle_inputs();
  endtask

  task automatic test_march_edge();
    apply_reset();
    for (int i = 0; i < 70 * 8; i++) do_tick();
    vectors += 2;
    if (grid_x !== 10'd320) begin miscompares++; $display("FAIL edge_x got=%0d exp=320", grid_x); end
    if (grid_y !== 10'd48) begin miscompares++; $display("FAIL edge_y got=%0d exp=48", grid_y); end
    for (int i = 0; i < 8; i++) do_tick();
    vectors += 2;
    if (grid_x !== 10'd320) begin miscompares++; $display("FAIL drop_x got=%0d exp=320", grid_x); end
    if (grid_y !== 10'd56) begin miscompares++; $display("FAIL drop_y got=%0d exp=56", grid_y); end
    for (int i = 0; i < 8; i++) do_tick();
    vectors += 2;
    if (grid_x !== 10'd316) begin miscompares++; $display("FAIL left_x got=%0d exp=316", grid_x); end
    if (grid_y !== 10'd56) begin miscompares++; $display("FAIL left_y got=%0d exp=56", grid_y); end
  endtask

  task automatic test_bottom();
    int guard;
    guard = 0;
    while (!m_rb && guard < 30000) begin
      do_tick();
      guard++;
      vectors++;
      if (grid_x !== 10'(m_x) || grid_y !== 10'(m_y) || reached_bottom !== m_rb) begin
        miscompares++;
        $display("FAIL march_track tick=%0d got=(%0d,%0d,%b) exp=(%0d,%0d,%b)",
                 guard, grid_x, grid_y, reached_bottom, m_x, m_y, m_rb);
      end
    end
    vectors += 3;
    if (!m_rb) begin miscompares++; $display("FAIL bottom_timeout ticks=%0d", guard); end
    if (grid_y !== 10'd344) begin miscompares++; $display("FAIL bottom_y got=%0d exp=344", grid_y); end
    if (grid_x !== 10'd320) begin miscompares++; $display("FAIL bottom_x got=%0d exp=320", grid_x); end
    for (int i = 0; i < 16; i++) do_tick();
    vectors += 3;
    if (reached_bottom !== 1'b1) begin miscompares++; $display("FAIL bottom_sticky got=%b exp=1", reached_bottom); end
    if (grid_y !== 10'd344) begin miscompares++; $display("FAIL bottom_frozen_y got=%0d exp=344", grid_y); end
    if (grid_x !== 10'd320) begin miscompares++; $display("FAIL bottom_frozen_x got=%0d exp=320", grid_x); end
    // Reset colliding with a frame tick and a kill
    reset = 1'b1;
    hpos = 10'd0; vpos = 10'd480;
    kill_valid = 1'b1; kill_row = 2'd0; kill_col = 3'd0;
    @(posedge clk); #1;
    vectors += 5;
    if (grid_x !== 10'd40) begin miscompares++; $display("FAIL midreset_x got=%0d exp=40", grid_x); end
    if (grid_y !== 10'd48) begin miscompares++; $display("FAIL midreset_y got=%0d exp=48", grid_y); end
    if (alive_count !== 6'd32) begin miscompares++; $display("FAIL midreset_count got=%0d exp=32", alive_count); end
    if (reached_bottom !== 1'b0) begin miscompares++; $display("FAIL midreset_bottom got=%b exp=0", reached_bottom); end
    if (all_dead !== 1'b0) begin miscompares++; $display("FAIL midreset_dead got=%b exp=0", all_dead); end
    kill_valid = 1'b0;
    hpos = 10'd48; vpos = 10'd48; display_on = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (alien_pixel !== 1'b0) begin miscompares++; $display("FAIL midreset_pixel got=%b exp=0", alien_pixel); end
    reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    vectors++;
    if (alien_pixel !== 1'b1) begin miscompares++; $display("FAIL after_reset_pixel got=%b exp=1", alien_pixel); end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    model_reset();
    test_reset();
    test_pixels();
    test_march_step();
    test_kill();
    test_all_dead();
    test_march_edge();
    test_bottom();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/invader_grid_renderer.md
INVADER_GRID_RENDERER -- requirements
Module: invader_grid_renderer

Interface
REQ-001 Parameter COLS, default 8, alien columns.
REQ-002 Parameter ROWS, default 4, alien rows.
REQ-003 Parameter MARCH_FRAMES, default 8, frames between march steps (1..255).
REQ-004 clk  input  1  pixel clock, the same clock that drives the VGA sync generator.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 hpos  input  10  current pixel column from the sync generator.
REQ-007 vpos  input  10  current pixel line from the sync generator.
REQ-008 display_on  input  1  active-video flag from the sync generator.
REQ-009 kill_valid  input  1  one-cycle pulse requesting removal of one alien.
REQ-010 kill_row  input  2  row index of the alien to remove (0 = top).
REQ-011 kill_col  input  3  column index of the alien to remove (0 = left).
REQ-012 alien_pixel  output  1  registered; high when the current pixel belongs to a live alien.
REQ-013 grid_x  output  10  grid origin column.
REQ-014 grid_y  output  10  grid origin line.
REQ-015 alive_count  output  6  number of live aliens.
REQ-016 all_dead  output  1  high when alive_count is 0.
REQ-017 reached_bottom  output  1  sticky flag set when the grid reaches the invasion line.

Function
REQ-018 Cell geometry is fixed: each cell is 40x24 px, and the sprite occupies the cell's top-left 32x16 px.
REQ-019 The sprite is an 8-line x 16-bit bitmap scaled 2x in both axes, so bitmap bit = (hpos-cell_x)>>1 and bitmap line = (vpos-cell_y)>>1.
REQ-020 The grid spans COLS*40 by ROWS*24 px (320x96 at the default parameters).
REQ-021 alien_pixel(n+1) = display_on(n) AND the pixel lies inside the grid AND the pixel lies inside the sprite area of its cell AND that cell's alive bit is set AND the bitmap bit is 1.
REQ-022 alien_pixel has exactly one cycle of latency relative to hpos/vpos.
REQ-023 Column and row indices are derived by subtraction from the grid origin and compare-and-subtract against the cell size; no divider is used.
REQ-024 frame_tick is defined as a one-cycle pulse at hpos==0 && vpos==480, the first blanking line.
REQ-025 frame_cnt counts frame_ticks from 0 to MARCH_FRAMES-1, then wraps to 0.
REQ-026 A march step occurs on the frame_tick at which frame_cnt wraps.
REQ-027 March state machine states are MARCH_RIGHT and MARCH_LEFT.
REQ-028 On a step in MARCH_RIGHT: if grid_x+COLS*40+4 > 640, then grid_y += 8 and the state changes to MARCH_LEFT; otherwise grid_x += 4.
REQ-029 On a step in MARCH_LEFT: if grid_x < 4, then grid_y += 8 and the state changes to MARCH_RIGHT; otherwise grid_x -= 4.
REQ-030 A drop step leaves grid_x unchanged.
REQ-031 Each march step, including a drop step, toggles anim_sel, which selects between the two bitmaps.
REQ-032 Position updates happen only on frame_tick, so there is no mid-frame tearing.
REQ-033 reached_bottom is set when grid_y+ROWS*24 >= 440 after a step; it stays set and marching stops while it is high.
REQ-034 Marching also stops while all_dead is high.
REQ-035 A kill clears alive[kill_row][kill_col] in the cycle after kill_valid, and alive_count decrements in that same cycle.
REQ-036 A kill on an already-dead cell, or on an index outside ROWS/COLS, has no effect.
REQ-037 A kill coinciding with a march step applies both updates in the same cycle.
REQ-038 A kill coinciding with pixel generation takes effect from the next pixel onward.

Reset
REQ-039 On reset: alive = all ones, alive_count = ROWS*COLS, grid_x = 40, grid_y = 48, state = MARCH_RIGHT, frame_cnt = 0, anim_sel = 0, alien_pixel = 0, reached_bottom = 0, all_dead = 0.
REQ-040 Reset asserted mid-frame or mid-kill overrides all other updates in that cycle.

Structure
REQ-041 A shared package holds the cell size, sprite size, step size (4 px horizontal, 8 px drop), start origin, invasion line 440, screen width 640, and the march-state encoding.
REQ-042 A sub-module invader_sprite_rom provides the combinational bitmap lookup: inputs anim_sel and line[2:0], output bits[15:0].

Verification
REQ-043 Reset, then run one frame with no kills -> grid_x=40, grid_y=48, alive_count=32, and alien_pixel high only inside the 8x4 cells at bitmap-1 positions, one cycle after the matching hpos/vpos.
REQ-044 Run 8 frame_ticks -> grid_x=44 and anim_sel=1; changes occur only at hpos=0, vpos=480.
REQ-045 March right until the edge -> step from grid_x=320 gives grid_x=320 (no change), grid_y=56, state MARCH_LEFT; next step gives grid_x=316.
REQ-046 kill_valid with row=2, col=5 -> alive_count 32->31 next cycle and that cell is dark on all later frames; repeated kill keeps 31; kill coinciding with a march step -> both applied.
REQ-047 Kill all 32 aliens -> all_dead=1, alive_count=0, and grid_x/grid_y frozen over the following 16 frames.
REQ-048 Force marching until grid_y+96 >= 440 -> reached_bottom=1 and stays set, position frozen; reset mid-frame -> all outputs return to their REQ-039 values on the next cycle.
